// File: rtl/spi_pkg.sv
// Shared SPI types and build constants for the slave and the master's debug decode.
// Bit order is selected by SPI_SLAVE_LSB_FIRST_EN (undefined: MSB first).
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int F_SIZE_DEF = 8;
    localparam int F_NUM_DEF  = 1;

`ifdef SPI_SLAVE_LSB_FIRST_EN
    localparam bit SPI_MSB_FIRST = 1'b0;
`else
    localparam bit SPI_MSB_FIRST = 1'b1;
`endif

endpackage

// File: rtl/spi_fsm_slave_if.sv
// SPI slave bus: serial pins plus the local tx/rx side and status flags.
// Bit order follows SPI_SLAVE_LSB_FIRST_EN via spi_pkg.
interface spi_fsm_slave_if #(
    parameter int F_SIZE = 8,
    parameter int F_NUM  = 1
);
    localparam int FC_SIZE = $clog2(F_NUM) + 1;

    logic               CS;
    logic               MOSI;
    logic               MISO;
    logic               miso_oe;
    logic [F_SIZE-1:0]  tx_data;
    logic               tx_load;
    logic [F_SIZE-1:0]  rx_data;
    logic               rx_tgl;
    logic [FC_SIZE-1:0] f_cnt;
    logic               frame_err;
    logic               overrun;

    modport master (
        output CS, MOSI, tx_data,
        input  MISO, miso_oe, tx_load, rx_data,
        input  rx_tgl, f_cnt, frame_err, overrun
    );

    modport slave (
        input  CS, MOSI, tx_data,
        output MISO, miso_oe, tx_load, rx_data,
        output rx_tgl, f_cnt, frame_err, overrun
    );

endinterface

// File: rtl/spi_slave_shifter.sv
// Rx/tx shift registers and the falling-edge MISO register.
// Shift direction set by SPI_SLAVE_LSB_FIRST_EN through spi_pkg.
module spi_slave_shifter
    import spi_pkg::*;
#(
    parameter int F_SIZE = F_SIZE_DEF
) (
    input  logic              sclk,
    input  logic              rst,
    input  logic              shift_en,
    input  logic              load,
    input  logic              mosi,
    input  logic [F_SIZE-1:0] tx_data,
    output logic [F_SIZE-1:0] rx_next,
    output logic              first_bit,
    output logic              miso_q
);

    logic [F_SIZE-1:0] rx_shift;
    logic [F_SIZE-1:0] tx_shift;
    logic [F_SIZE-1:0] tx_next;
    logic              tx_bit;

    // Next shift values and the bit presented at each frame position
    always_comb begin
        rx_next   = rx_shift;
        tx_next   = tx_shift;
        first_bit = 1'b0;
        tx_bit    = 1'b0;
        if (SPI_MSB_FIRST) begin
            rx_next   = {rx_shift[F_SIZE-2:0], mosi};
            tx_next   = load ? (tx_data << 1) : (tx_shift << 1);
            first_bit = tx_data[F_SIZE-1];
            tx_bit    = tx_shift[F_SIZE-1];
        end else begin
            rx_next   = {mosi, rx_shift[F_SIZE-1:1]};
            tx_next   = load ? (tx_data >> 1) : (tx_shift >> 1);
            first_bit = tx_data[0];
            tx_bit    = tx_shift[0];
        end
    end

    // Sample MOSI and advance the tx shifter on rising SCLK
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            rx_shift <= '0;
            tx_shift <= '0;
        end else if (shift_en) begin
            rx_shift <= rx_next;
            tx_shift <= tx_next;
        end
    end

    // Launch the next MISO bit on falling SCLK
    always_ff @(negedge sclk or posedge rst) begin
        if (rst) begin
            miso_q <= 1'b0;
        end else begin
            miso_q <= load ? first_bit : tx_bit;
        end
    end

endmodule

// File: rtl/spi_fsm_slave.sv
// SPI mode-0 slave: FSM, bit/frame counters, rx capture and sticky flags.
// SPI_SLAVE_LSB_FIRST_EN selects LSB-first shifting (default MSB first).
module spi_fsm_slave
    import spi_pkg::*;
#(
    parameter int F_SIZE  = F_SIZE_DEF,
    parameter int F_NUM   = F_NUM_DEF,
    parameter int C_SIZE  = $clog2(F_SIZE) + 1,
    parameter int FC_SIZE = $clog2(F_NUM) + 1
) (
    input logic          rst,
    input logic          SCLK,
    spi_fsm_slave_if.slave bus
);

    state_t             state;
    state_t             state_nx;
    logic [C_SIZE-1:0]  bit_cnt;
    logic [FC_SIZE-1:0] f_cnt;
    logic [F_SIZE-1:0]  rx_data;
    logic               rx_tgl;
    logic               frame_err;
    logic               overrun;
    logic               shift_en;
    logic               load;
    logic               frame_end;
    logic               last_frame;
    logic               miso;
    logic [F_SIZE-1:0]  rx_next;
    logic               first_bit;
    logic               miso_q;

    spi_slave_shifter #(.F_SIZE(F_SIZE)) u_shift (
        .sclk      (SCLK),
        .rst       (rst),
        .shift_en  (shift_en),
        .load      (load),
        .mosi      (bus.MOSI),
        .tx_data   (bus.tx_data),
        .rx_next   (rx_next),
        .first_bit (first_bit),
        .miso_q    (miso_q)
    );

    // State and counters; CS high clears them without an SCLK edge
    always_ff @(posedge SCLK or posedge rst or posedge bus.CS) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            f_cnt   <= '0;
        end else if (bus.CS) begin
            state   <= IDLE;
            bit_cnt <= '0;
            f_cnt   <= '0;
        end else begin
            state <= state_nx;
            if (shift_en) begin
                bit_cnt <= frame_end ? '0 : bit_cnt + 1'b1;
            end
            if (frame_end) begin
                f_cnt <= f_cnt + 1'b1;
            end
        end
    end

    // Next state: leave for DONE on the edge completing the last frame
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE, SHIFT: state_nx = (frame_end && last_frame) ? DONE : SHIFT;
            DONE:        state_nx = DONE;
            default:     state_nx = IDLE;
        endcase
    end

    // Datapath controls and MISO mux
    always_comb begin
        shift_en   = !bus.CS && (state != DONE);
        load       = (bit_cnt == '0);
        frame_end  = shift_en && (bit_cnt == C_SIZE'(F_SIZE - 1));
        last_frame = (f_cnt == FC_SIZE'(F_NUM - 1));
        miso       = 1'b0;
        if (!rst && !bus.CS) begin
            unique case (state)
                IDLE:    miso = first_bit;
                DONE:    miso = 1'b0;
                default: miso = miso_q;
            endcase
        end
    end

    // Frame capture and overrun; these survive CS and clear only on rst
    always_ff @(posedge SCLK or posedge rst) begin
        if (rst) begin
            rx_data <= '0;
            rx_tgl  <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (frame_end) begin
                rx_data <= rx_next;
                rx_tgl  <= ~rx_tgl;
            end
            if (!bus.CS && state == DONE) begin
                overrun <= 1'b1;
            end
        end
    end

    // CS rising mid-frame flags a truncated frame
    always_ff @(posedge bus.CS or posedge rst) begin
        if (rst) begin
            frame_err <= 1'b0;
        end else if (bit_cnt != '0) begin
            frame_err <= 1'b1;
        end
    end

    assign bus.MISO      = miso;
    assign bus.miso_oe   = ~bus.CS;
    assign bus.tx_load   = load && !bus.CS;
    assign bus.rx_data   = rx_data;
    assign bus.rx_tgl    = rx_tgl;
    assign bus.f_cnt     = f_cnt;
    assign bus.frame_err = frame_err;
    assign bus.overrun   = overrun;

endmodule

// File: tb/tb_spi_fsm_slave.sv
// Directed bench for spi_fsm_slave: one-frame and two-frame slaves side by side.
// Define SPI_SLAVE_LSB_FIRST_EN to run the LSB-first vector instead of the MSB-first set.
module tb_spi_fsm_slave;
    import spi_pkg::*;

    logic       rst;
    logic       sclk0;
    logic       sclk1;
    logic       cs0;
    logic       cs1;
    logic       mosi;
    logic [7:0] txd;
    logic [7:0] m1;
    logic [7:0] m2;
    logic       mb;
    int         n_chk;
    int         n_fail;

    spi_fsm_slave_if #(.F_SIZE(8), .F_NUM(1)) i1 ();
    spi_fsm_slave_if #(.F_SIZE(8), .F_NUM(2)) i2 ();

    assign i1.CS      = cs0;
    assign i1.MOSI    = mosi;
    assign i1.tx_data = txd;
    assign i2.CS      = cs1;
    assign i2.MOSI    = mosi;
    assign i2.tx_data = txd;

    spi_fsm_slave #(.F_SIZE(8), .F_NUM(1)) u1 (
        .rst  (rst),
        .SCLK (sclk0),
        .bus  (i1)
    );

    spi_fsm_slave #(.F_SIZE(8), .F_NUM(2)) u2 (
        .rst  (rst),
        .SCLK (sclk1),
        .bus  (i2)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One SCLK period; MISO sampled just before the rising edge.
    // sw[8] requests tx_data <= sw[7:0] between rise and fall.
    task automatic bitc(input int s, input logic b, output logic m,
                        input logic [8:0] sw);
        mosi = b;
        #2;
        m = (s == 0) ? i1.MISO : i2.MISO;
        #3;
        if (s == 0) sclk0 = 1'b1; else sclk1 = 1'b1;
        #2;
        if (sw[8]) txd = sw[7:0];
        #3;
        if (s == 0) sclk0 = 1'b0; else sclk1 = 1'b0;
    endtask

    task automatic frame(input int s, input logic [7:0] d, input int n,
                         output logic [7:0] mis, input logic [8:0] sw);
        logic m;
        mis = '0;
        for (int i = 0; i < n; i++) begin
            bitc(s, d[7-i], m, (i == n - 1) ? sw : 9'h0);
            mis[7-i] = m;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        sclk0  = 1'b0;
        sclk1  = 1'b0;
        cs0    = 1'b1;
        cs1    = 1'b1;
        mosi   = 1'b0;
        txd    = 8'h00;
        #10;
        chk("rst_rx", 32'(i1.rx_data), 32'h00);
        chk("rst_tgl", 32'(i1.rx_tgl), 32'h0);
        chk("rst_ferr", 32'(i1.frame_err), 32'h0);
        chk("rst_ovr", 32'(i1.overrun), 32'h0);
        chk("rst_miso", 32'(i1.MISO), 32'h0);
        chk("rst_oe", 32'(i1.miso_oe), 32'h0);
        rst = 1'b0;
        #5;

`ifdef SPI_SLAVE_LSB_FIRST_EN
        txd = 8'h01;
        cs0 = 1'b0;
        #3;
        frame(0, 8'h80, 8, m1, 9'h0);
        chk("lsb_first", 32'(m1[7]), 32'h1);
        chk("lsb_rx", 32'(i1.rx_data), 32'h01);
        chk("lsb_tgl", 32'(i1.rx_tgl), 32'h1);
        cs0 = 1'b1;
        #5;
`else
        txd = 8'hA5;
        cs0 = 1'b0;
        #3;
        chk("t1_oe", 32'(i1.miso_oe), 32'h1);
        chk("t1_load", 32'(i1.tx_load), 32'h1);
        frame(0, 8'h3C, 8, m1, 9'h0);
        chk("t1_miso", 32'(m1), 32'hA5);
        chk("t1_rx", 32'(i1.rx_data), 32'h3C);
        chk("t1_tgl", 32'(i1.rx_tgl), 32'h1);
        chk("t1_fcnt", 32'(i1.f_cnt), 32'h1);
        chk("t1_state", 32'(u1.state), 32'(DONE));
        cs0 = 1'b1;
        #5;
        chk("t1_fcnt_cs", 32'(i1.f_cnt), 32'h0);
        chk("t1_ferr", 32'(i1.frame_err), 32'h0);

        cs0 = 1'b0;
        #3;
        frame(0, 8'hFF, 5, m1, 9'h0);
        cs0 = 1'b1;
        #3;
        chk("t3_ferr", 32'(i1.frame_err), 32'h1);
        chk("t3_rx", 32'(i1.rx_data), 32'h3C);
        chk("t3_bcnt", 32'(u1.bit_cnt), 32'h0);
        chk("t3_tgl", 32'(i1.rx_tgl), 32'h1);
        txd = 8'h81;
        cs0 = 1'b0;
        #3;
        frame(0, 8'hC3, 8, m1, 9'h0);
        chk("t3_rx2", 32'(i1.rx_data), 32'hC3);
        chk("t3_miso2", 32'(m1), 32'h81);
        chk("t3_tgl2", 32'(i1.rx_tgl), 32'h0);
        cs0 = 1'b1;
        #5;

        cs0 = 1'b0;
        #3;
        frame(0, 8'h5A, 8, m1, 9'h0);
        chk("t4_ovr0", 32'(i1.overrun), 32'h0);
        bitc(0, 1'b1, mb, 9'h0);
        #1;
        chk("t4_ovr", 32'(i1.overrun), 32'h1);
        chk("t4_rx", 32'(i1.rx_data), 32'h5A);
        chk("t4_tgl", 32'(i1.rx_tgl), 32'h1);
        chk("t4_miso", 32'(i1.MISO), 32'h0);
        cs0 = 1'b1;
        #5;
        chk("t4_ovr_cs", 32'(i1.overrun), 32'h1);

        txd = 8'hF0;
        cs1 = 1'b0;
        #3;
        frame(1, 8'h12, 8, m1, 9'h10F);
        chk("t2_miso1", 32'(m1), 32'hF0);
        chk("t2_rx1", 32'(i2.rx_data), 32'h12);
        chk("t2_fcnt1", 32'(i2.f_cnt), 32'h1);
        chk("t2_tgl1", 32'(i2.rx_tgl), 32'h1);
        frame(1, 8'h34, 8, m2, 9'h0);
        chk("t2_miso2", 32'(m2), 32'h0F);
        chk("t2_rx2", 32'(i2.rx_data), 32'h34);
        chk("t2_fcnt2", 32'(i2.f_cnt), 32'h2);
        chk("t2_state", 32'(u2.state), 32'(DONE));
        chk("t2_tgl2", 32'(i2.rx_tgl), 32'h0);
        cs1 = 1'b1;
        #5;
`endif

        txd = 8'hFF;
        cs0 = 1'b0;
        #3;
        frame(0, 8'hAA, 4, m1, 9'h0);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_rx", 32'(i1.rx_data), 32'h00);
        chk("t5_tgl", 32'(i1.rx_tgl), 32'h0);
        chk("t5_ferr", 32'(i1.frame_err), 32'h0);
        chk("t5_ovr", 32'(i1.overrun), 32'h0);
        chk("t5_miso", 32'(i1.MISO), 32'h0);
        chk("t5_fcnt", 32'(i1.f_cnt), 32'h0);
        chk("t5_bcnt", 32'(u1.bit_cnt), 32'h0);
        chk("t5_state", 32'(u1.state), 32'(IDLE));
        rst = 1'b0;
        cs0 = 1'b1;
        #5;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
